// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel active-low key synchroniser/debouncer with press,
//            release and optional long-press pulses (KEY_LONG_PRESS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
   parameter int N_KEYS      = 4,
   parameter int SAMPLE_TIME = 1000000,
   parameter int CNT_W       = 23,
   parameter int LONG_TIME   = 50000000,
   parameter int LONG_W      = 26
) (
   input  logic              clk,
   input  logic              nCR,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_out,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);

   localparam logic [CNT_W-1:0] C_SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic             sync1_q;
      logic             sync2_q;
      logic [CNT_W-1:0] dcnt_q;
      logic [CNT_W-1:0] dcnt_d;
      logic             out_q;
      logic             out_d;
      logic             press_q;
      logic             release_q;
      logic             dbnc_done;

      // The count only survives while every synced sample disagrees with out_q.
      always_comb begin
         dcnt_d    = '0;
         out_d     = out_q;
         dbnc_done = 1'b0;
         if (sync2_q != out_q) begin
            if (dcnt_q == C_SAMPLE_LAST) begin
               out_d     = sync2_q;
               dbnc_done = 1'b1;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!nCR) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            dcnt_q    <= '0;
            out_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync1_q   <= key_in[i];
            sync2_q   <= sync1_q;
            dcnt_q    <= dcnt_d;
            out_q     <= out_d;
            press_q   <= dbnc_done & ~sync2_q;
            release_q <= dbnc_done &  sync2_q;
         end
      end

      assign key_out[i]     = out_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;

`ifdef KEY_LONG_PRESS_EN
      localparam logic [LONG_W-1:0] C_LONG_LAST = LONG_W'(LONG_TIME - 1);

      logic [LONG_W-1:0] lcnt_q;
      logic [LONG_W-1:0] lcnt_d;
      logic              fired_q;
      logic              fired_d;
      logic              long_q;
      logic              long_d;

      // A release being accepted this cycle clears the hold so key_long and
      // key_release can never land in the same cycle.
      always_comb begin
         lcnt_d  = lcnt_q;
         fired_d = fired_q;
         long_d  = 1'b0;
         if (out_q || dbnc_done) begin
            lcnt_d  = '0;
            fired_d = 1'b0;
         end else if (!fired_q) begin
            if (lcnt_q == C_LONG_LAST) begin
               long_d  = 1'b1;
               fired_d = 1'b1;
            end else begin
               lcnt_d = lcnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!nCR) begin
            lcnt_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
         end else begin
            lcnt_q  <= lcnt_d;
            fired_q <= fired_d;
            long_q  <= long_d;
         end
      end

      assign key_long[i] = long_q;
`else
      assign key_long[i] = 1'b0;
`endif
   end : g_ch

endmodule : key_debounce_multi
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_multi
// Brief    : Directed bench for key_debounce_multi with an event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

   localparam int C_ST  = 4;
   localparam int C_LT  = 10;
   localparam int C_LAT = C_ST + 2;

   logic       clk;
   logic       nCR;
   logic [3:0] key_in;
   logic [3:0] key_out;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic [3:0] key_long;

   key_debounce_multi #(
      .N_KEYS      (4),
      .SAMPLE_TIME (C_ST),
      .CNT_W       (8),
      .LONG_TIME   (C_LT),
      .LONG_W      (8)
   ) dut (
      .clk         (clk),
      .nCR         (nCR),
      .key_in      (key_in),
      .key_out     (key_out),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   typedef struct {
      int         at;
      logic [3:0] p;
      logic [3:0] r;
      logic [3:0] l;
   } ev_t;

   ev_t  evq[$];
   int   cyc;
   bit   rst_at_edge;
   bit   started;
   int   n_assert;
   int   n_fail;
   logic [3:0] exp_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      rst_at_edge = !nCR;
   end

   function automatic logic [3:0] lv(input logic [3:0] x);
`ifdef KEY_LONG_PRESS_EN
      return x;
`else
      return 4'b0000 & x;
`endif
   endfunction

   // Keeps the queue ordered by cycle; events due in the same cycle merge.
   task automatic push_ev(input int at, input logic [3:0] p,
                          input logic [3:0] r, input logic [3:0] l);
      ev_t e;
      for (int i = 0; i < evq.size(); i++) begin
         if (evq[i].at == at) begin
            e = evq[i];
            e.p |= p; e.r |= r; e.l |= l;
            evq[i] = e;
            return;
         end
         if (evq[i].at > at) begin
            e.at = at; e.p = p; e.r = r; e.l = l;
            evq.insert(i, e);
            return;
         end
      end
      e.at = at; e.p = p; e.r = r; e.l = l;
      evq.push_back(e);
   endtask

   always @(negedge clk) begin
      logic [3:0] ep, er, el;
      ev_t e;
      if (started) begin
         ep = 4'b0; er = 4'b0; el = 4'b0;
         if (rst_at_edge) begin
            exp_out = 4'b1111;
         end else begin
            if (evq.size() > 0 && evq[0].at < cyc) begin
               n_assert++;
               n_fail++;
               $error("FAIL stale_event cyc=%0d observed=missed expected_at=%0d", cyc, evq[0].at);
               void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].at == cyc) begin
               e  = evq.pop_front();
               ep = e.p; er = e.r; el = e.l;
               exp_out = (exp_out & ~e.p) | e.r;
            end
         end
         n_assert++;
         assert (key_out === exp_out) else begin
            n_fail++;
            $error("FAIL key_out cyc=%0d observed=%b expected=%b", cyc, key_out, exp_out);
         end
         n_assert++;
         assert (key_press === ep) else begin
            n_fail++;
            $error("FAIL key_press cyc=%0d observed=%b expected=%b", cyc, key_press, ep);
         end
         n_assert++;
         assert (key_release === er) else begin
            n_fail++;
            $error("FAIL key_release cyc=%0d observed=%b expected=%b", cyc, key_release, er);
         end
         n_assert++;
         assert (key_long === el) else begin
            n_fail++;
            $error("FAIL key_long cyc=%0d observed=%b expected=%b", cyc, key_long, el);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      cyc      = 0;
      n_assert = 0;
      n_fail   = 0;
      started  = 1'b0;
      exp_out  = 4'b1111;
      nCR      = 1'b0;
      key_in   = 4'b0000;

      // Reset with all keys held; they are accepted once reset releases.
      tick(1);
      started = 1'b1;
      tick(2);
      nCR = 1'b1;
      push_ev(cyc + C_LAT, 4'b1111, 4'b0, 4'b0);
      push_ev(cyc + C_LAT + C_LT, 4'b0, 4'b0, lv(4'b1111));
      tick(20);
      key_in = 4'b1111;
      push_ev(cyc + C_LAT, 4'b0, 4'b1111, 4'b0);
      tick(10);

      // Clean press on ch0, held well past the long-press point.
      key_in[0] = 1'b0;
      push_ev(cyc + C_LAT, 4'b0001, 4'b0, 4'b0);
      push_ev(cyc + C_LAT + C_LT, 4'b0, 4'b0, lv(4'b0001));
      tick(8);

      // Bounce on ch1: low runs shorter than SAMPLE_TIME are rejected.
      repeat (5) begin
         key_in[1] = 1'b0;
         tick(3);
         key_in[1] = 1'b1;
         tick(1);
      end
      tick(10);

      // ch2/ch3 together, then release ch2 only.
      key_in[3:2] = 2'b00;
      push_ev(cyc + C_LAT, 4'b1100, 4'b0, 4'b0);
      push_ev(cyc + C_LAT + C_LT, 4'b0, 4'b0, lv(4'b1100));
      tick(20);
      key_in[2] = 1'b1;
      push_ev(cyc + C_LAT, 4'b0, 4'b0100, 4'b0);
      tick(10);

      key_in = 4'b1111;
      push_ev(cyc + C_LAT, 4'b0, 4'b1001, 4'b0);
      tick(10);

      // Reset pulse while ch0 is held discards the pending long press.
      key_in[0] = 1'b0;
      push_ev(cyc + C_LAT, 4'b0001, 4'b0, 4'b0);
      tick(C_LAT);
      tick(5);
      nCR = 1'b0;
      evq.delete();
      tick(1);
      nCR = 1'b1;
      push_ev(cyc + C_LAT, 4'b0001, 4'b0, 4'b0);
      push_ev(cyc + C_LAT + C_LT, 4'b0, 4'b0, lv(4'b0001));
      tick(25);
      key_in = 4'b1111;
      push_ev(cyc + C_LAT, 4'b0, 4'b0001, 4'b0);
      tick(12);

      n_assert++;
      assert (evq.size() == 0) else begin
         n_fail++;
         $error("FAIL queue_drained observed=%0d pending expected=0", evq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_key_debounce_multi
`default_nettype wire

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel push-button conditioner. Each channel synchronises a raw active-low key input, debounces it with a per-channel stability counter, and emits the stable level plus one-cycle press/release pulses. An optional long-press pulse is also available. It sits between the board key pins and the control/menu logic, and replaces per-key single-channel debouncers with one instance.

## Interface
- `N_KEYS`, default 4: number of independent key channels (≥1).
- `SAMPLE_TIME`, default 1000000: consecutive stable cycles required to accept a new level (1 ≤ SAMPLE_TIME < 2^CNT_W).
- `CNT_W`, default 23: debounce counter width per channel.
- `LONG_TIME`, default 50000000: cycles of debounced press before `key_long` fires (1 ≤ LONG_TIME < 2^LONG_W).
- `LONG_W`, default 26: long-press counter width per channel.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `nCR`, in, 1: reset, synchronous, active-low.
- `key_in`, in, N_KEYS: raw asynchronous key pins. 0 = pressed.
- `key_out`, out, N_KEYS: debounced level. 0 = pressed.
- `key_press`, out, N_KEYS: one-cycle pulse on the debounced 1→0 transition.
- `key_release`, out, N_KEYS: one-cycle pulse on the debounced 0→1 transition.
- `key_long`, out, N_KEYS: one-cycle pulse when a press has been held for LONG_TIME cycles.

## Operation
Channels are fully independent and identical. For channel i:
- **Synchroniser.** Two flops give `s[i]`. Both reset to 1.
- **Debounce counter `dcnt`.**
  - If `s[i] == key_out[i]`: `dcnt` ← 0.
  - Otherwise: `dcnt` ← `dcnt` + 1.
  - When `s[i] != key_out[i]` and `dcnt == SAMPLE_TIME-1`: `key_out[i]` ← `s[i]` and `dcnt` ← 0.
  - Net effect: the level is accepted after exactly SAMPLE_TIME consecutive differing synced samples.
  - Any intervening sample equal to `key_out[i]` restarts the count.
- **Edge pulses.** Registered outputs.
  - `key_press[i]` = 1 in exactly the first cycle in which `key_out[i]` reads 0.
  - `key_release[i]` = 1 in exactly the first cycle in which `key_out[i]` reads 1 after a press.
- **Long press `lcnt`.**
  - While `key_out[i] == 1`: `lcnt` ← 0 and the per-press `fired` flag ← 0.
  - While `key_out[i] == 0` and `fired == 0`: `lcnt` increments.
  - When `lcnt == LONG_TIME-1`: `key_long[i]` pulses for one cycle and `fired` ← 1.
  - At most one `key_long` per press. `lcnt` does not wrap.
- **Counter widths.** Counters saturate by construction (they clear at the terminal count). No overflow is possible within the parameter limits.

Reset (`nCR` = 0 at a clk edge):
- `key_out` = all 1.
- `key_press`, `key_release`, `key_long` = all 0.
- All counters = 0, sync flops = 1, `fired` = 0.
- Reset mid-debounce or mid-hold discards progress.
- No pulse is generated by reset entry or exit.
- A key already held when reset releases produces `key_press` SAMPLE_TIME+2 cycles after release.

## Timing
- **Press latency.** `key_in` falls and stays low. `key_out` falls SAMPLE_TIME+2 cycles later: 2 cycles of sync, then SAMPLE_TIME cycles of counting. `key_press` is high in that same cycle.
- **Release latency.** Symmetric: SAMPLE_TIME+2 cycles to `key_out` rising and `key_release`.
- **Long-press latency.** `key_long` asserts LONG_TIME cycles after the `key_press` cycle.
- **Simultaneous events.** Different channels may pulse in the same cycle. Within one channel:
  - `key_press` and `key_release` are never both high.
  - `key_long` never coincides with `key_release`.
- **Glitch rejection.** A differing pulse of 1 to SAMPLE_TIME-1 synced cycles produces no output change.

## Configuration
- **`KEY_LONG_PRESS_EN` defined:** the long-press counters and `fired` flags are built, and `key_long` behaves as above.
- **`KEY_LONG_PRESS_EN` not defined:** no long-press logic is instantiated. `key_long` is tied to all 0. LONG_TIME and LONG_W are ignored. All other behaviour is identical.

## Test plan
All scenarios use N_KEYS=4, SAMPLE_TIME=4, LONG_TIME=10, with `KEY_LONG_PRESS_EN` defined unless stated.
- **Reset.** Hold `nCR`=0 for 3 cycles with `key_in`=4'b0000. Required: `key_out`=4'b1111 and all pulses 0 during reset; `key_out[3:0]`=0 and `key_press`=4'b1111 exactly 6 cycles after `nCR` rises.
- **Clean press.** Drive `key_in[0]` 1→0 and hold. Required: `key_out[0]` falls 6 cycles later with a 1-cycle `key_press[0]`; `key_long[0]` pulses once, 10 cycles after `key_press`, and not again while held.
- **Bounce.** `key_in[1]` toggles low 3 cycles, high 1 cycle, repeated 5 times, then stays high. Required: `key_out[1]` stays 1 and no pulses.
- **Parallel channels and release.** Press ch2 and ch3 in the same cycle, hold 20 cycles, release ch2 only. Required: `key_press`=4'b1100 in one cycle; `key_release`=4'b0100 6 cycles after the ch2 release; ch3 remains 0.
- **Reset mid-hold.** Pulse `nCR` low for 1 cycle while ch0 is held, 5 cycles after `key_press[0]`. Required: `key_out[0]`=1 after reset with no `key_release`; `key_press[0]` again 6 cycles later; `key_long[0]` 10 cycles after that.
- **Macro off.** Rebuild without `KEY_LONG_PRESS_EN` and repeat the clean-press scenario. Required: `key_long`=0 throughout; press timing unchanged.
